// File: rtl/rpn_eval.sv
// Postfix evaluator: consumes ASCII digit/operator tokens, evaluates on a register
// stack and emits one signed result per '='. Errors are sticky until the next '='.
module rpn_eval #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TOK_VALID,
    input  logic [7:0]       TOK_DATA,
    output logic             TOK_READY,
    output logic             RES_VALID,
    output logic [WIDTH-1:0] RES_DATA,
    output logic             ERR,
    output logic [1:0]       ERR_CODE
);

    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] CODE_UNDER = 2'b00;
    localparam logic [1:0] CODE_OVER  = 2'b01;
    localparam logic [1:0] CODE_DIV0  = 2'b10;
    localparam logic [1:0] CODE_BAD   = 2'b11;

    localparam logic [7:0] TK_ADD   = 8'd43;
    localparam logic [7:0] TK_SUB   = 8'd45;
    localparam logic [7:0] TK_MUL   = 8'd42;
    localparam logic [7:0] TK_DIV   = 8'd47;
    localparam logic [7:0] TK_EQ    = 8'd61;
    localparam logic [7:0] TK_SPACE = 8'd32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIV,
        ST_WB,
        ST_ERROR
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL
    } op_t;

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [WIDTH-1:0] res_q, res_d;
    logic             rv_q, rv_d;
    logic [1:0]       code_q, code_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             neg_q, neg_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [AW-1:0]    idx_a, idx_b, idx_push;
    logic [WIDTH-1:0] top_a, top_b;
    logic             tok_digit, tok_op, tok_eq, tok_space;
    logic [WIDTH:0]   rem_sh, diff;
    logic [WIDTH-1:0] alu;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

    assign idx_a    = AW'(sp_q - SPW'(1));
    assign idx_b    = AW'(sp_q - SPW'(2));
    assign idx_push = AW'(sp_q);
    assign top_a    = stk_q[idx_a];
    assign top_b    = stk_q[idx_b];

    assign tok_digit = (TOK_DATA >= 8'd48) && (TOK_DATA <= 8'd57);
    assign tok_op    = (TOK_DATA == TK_ADD) || (TOK_DATA == TK_SUB) ||
                       (TOK_DATA == TK_MUL) || (TOK_DATA == TK_DIV);
    assign tok_eq    = (TOK_DATA == TK_EQ);
    assign tok_space = (TOK_DATA == TK_SPACE);

    // One restoring step: the dividend shifts out of quo_q as quotient bits shift in.
    assign rem_sh = {rem_q, quo_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        sp_d      = sp_q;
        stk_d     = stk_q;
        res_d     = res_q;
        rv_d      = 1'b0;
        code_d    = code_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_d     = neg_q;
        cnt_d     = cnt_q;
        alu       = '0;
        TOK_READY = 1'b0;

        case (state_q)
            ST_IDLE: begin
                TOK_READY = 1'b1;
                if (TOK_VALID) begin
                    if (tok_digit) begin
                        if (sp_q == SPW'(DEPTH)) begin
                            state_d = ST_ERROR;
                            code_d  = CODE_OVER;
                        end else begin
                            stk_d[idx_push] = WIDTH'(TOK_DATA[3:0]);
                            sp_d            = sp_q + SPW'(1);
                        end
                    end else if (tok_op) begin
                        if (sp_q < SPW'(2)) begin
                            state_d = ST_ERROR;
                            code_d  = CODE_UNDER;
                        end else if (TOK_DATA == TK_DIV) begin
                            if (top_a == '0) begin
                                state_d = ST_ERROR;
                                code_d  = CODE_DIV0;
                            end else begin
                                state_d = ST_DIV;
                                rem_d   = '0;
                                quo_d   = mag(top_b);
                                dvs_d   = mag(top_a);
                                neg_d   = top_a[WIDTH-1] ^ top_b[WIDTH-1];
                                cnt_d   = '0;
                            end
                        end else begin
                            state_d = ST_EXEC;
                            op_d    = (TOK_DATA == TK_ADD) ? OP_ADD :
                                      (TOK_DATA == TK_SUB) ? OP_SUB : OP_MUL;
                        end
                    end else if (tok_eq) begin
                        if (sp_q == SPW'(1)) begin
                            res_d = top_a;
                            rv_d  = 1'b1;
                            sp_d  = '0;
                        end else begin
                            state_d = ST_ERROR;
                            code_d  = CODE_BAD;
                        end
                    end else if (!tok_space) begin
                        state_d = ST_ERROR;
                        code_d  = CODE_BAD;
                    end
                end
            end

            ST_EXEC: begin
                case (op_q)
                    OP_ADD:  alu = top_b + top_a;
                    OP_SUB:  alu = top_b - top_a;
                    default: alu = top_b * top_a;
                endcase
                stk_d[idx_b] = alu;
                sp_d         = sp_q - SPW'(1);
                state_d      = ST_IDLE;
            end

            ST_DIV: begin
                rem_d = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = ST_WB;
                end
            end

            ST_WB: begin
                // Negating 2^(WIDTH-1) wraps onto itself, which gives MIN / -1 = MIN.
                stk_d[idx_b] = neg_q ? -quo_q : quo_q;
                sp_d         = sp_q - SPW'(1);
                state_d      = ST_IDLE;
            end

            ST_ERROR: begin
                TOK_READY = 1'b1;
                if (TOK_VALID && tok_eq) begin
                    state_d = ST_IDLE;
                    code_d  = CODE_UNDER;
                    sp_d    = '0;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            op_q    <= OP_ADD;
            sp_q    <= '0;
            stk_q   <= '{default: '0};
            res_q   <= '0;
            rv_q    <= 1'b0;
            code_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sp_q    <= sp_d;
            stk_q   <= stk_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            code_q  <= code_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign RES_VALID = rv_q;
    assign RES_DATA  = res_q;
    assign ERR       = (state_q == ST_ERROR);
    assign ERR_CODE  = code_q;

endmodule

// File: tb/tb_rpn_eval.sv
// Bench for rpn_eval: directed cases plus random token streams, checked against a
// queue-based postfix evaluator.
module tb_rpn_eval;

    localparam int WIDTH = 16;
    localparam int DEPTH = 16;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             TOK_VALID = 1'b0;
    logic [7:0]       TOK_DATA = 8'd0;
    logic             TOK_READY;
    logic             RES_VALID;
    logic [WIDTH-1:0] RES_DATA;
    logic             ERR;
    logic [1:0]       ERR_CODE;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int               stk[$];
    bit               m_err  = 1'b0;
    logic [1:0]       m_code = 2'b00;
    logic [WIDTH-1:0] m_res  = '0;
    bit               m_rv   = 1'b0;

    rpn_eval #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TOK_VALID(TOK_VALID),
        .TOK_DATA (TOK_DATA),
        .TOK_READY(TOK_READY),
        .RES_VALID(RES_VALID),
        .RES_DATA (RES_DATA),
        .ERR      (ERR),
        .ERR_CODE (ERR_CODE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int wrap16(input int v);
        shortint s;
        s = shortint'(v);
        return int'(s);
    endfunction

    task automatic model_flag(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
    endtask

    task automatic model_reset();
        stk.delete();
        m_err  = 1'b0;
        m_code = 2'b00;
        m_res  = '0;
        m_rv   = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] t);
        int a, b, r;
        m_rv = 1'b0;
        if (m_err) begin
            if (t == 8'd61) begin
                m_err  = 1'b0;
                m_code = 2'b00;
                stk.delete();
            end
            return;
        end
        if (t >= 8'd48 && t <= 8'd57) begin
            if (stk.size() == DEPTH) model_flag(2'b01);
            else stk.push_back(int'(t) - 48);
        end else if (t == 8'd43 || t == 8'd45 || t == 8'd42 || t == 8'd47) begin
            if (stk.size() < 2) begin
                model_flag(2'b00);
            end else begin
                a = stk[$];
                b = stk[$-1];
                if (t == 8'd47 && a == 0) begin
                    model_flag(2'b10);
                end else begin
                    case (t)
                        8'd43:   r = b + a;
                        8'd45:   r = b - a;
                        8'd42:   r = b * a;
                        default: r = b / a;
                    endcase
                    void'(stk.pop_back());
                    void'(stk.pop_back());
                    stk.push_back(wrap16(r));
                end
            end
        end else if (t == 8'd61) begin
            if (stk.size() == 1) begin
                m_res = WIDTH'(stk[0]);
                m_rv  = 1'b1;
                stk.delete();
            end else begin
                model_flag(2'b11);
            end
        end else if (t != 8'd32) begin
            model_flag(2'b11);
        end
    endtask

    task automatic send(input logic [7:0] t);
        int n = 0;
        TOK_VALID = 1'b1;
        TOK_DATA  = t;
        while (!TOK_READY && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
        if (!TOK_READY) begin
            chk("accept_timeout", 32'(TOK_READY), 32'd1);
            TOK_VALID = 1'b0;
            return;
        end
        @(posedge CLK); #1;
        TOK_VALID = 1'b0;
        model_step(t);
        chk("res_valid", 32'(RES_VALID), 32'(m_rv));
        chk("res_data",  32'(RES_DATA),  32'(m_res));
        chk("err",       32'(ERR),       32'(m_err));
        chk("err_code",  32'(ERR_CODE),  32'(m_code));
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        while (!TOK_READY && n < 200) begin
            @(posedge CLK); #1;
            n++;
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_ready"},    32'(TOK_READY), 32'd1);
        chk({tag, "_rv"},       32'(RES_VALID), 32'd0);
        chk({tag, "_res"},      32'(RES_DATA),  32'd0);
        chk({tag, "_err"},      32'(ERR),       32'd0);
        chk({tag, "_err_code"}, 32'(ERR_CODE),  32'd0);
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] tok;
        logic [7:0] bad_toks [4];
        bad_toks = '{8'h61, 8'h23, 8'h00, 8'h3C};

        repeat (2) @(posedge CLK);
        #1;
        check_reset_values("in_reset");
        RST = 1'b0;
        @(posedge CLK); #1;
        check_reset_values("post_reset");

        send("3"); send("4"); send("+");
        busy_cycles(n);
        chk("add_busy_cycles", 32'(n), 32'd1);
        send("=");
        chk("add_rv", 32'(RES_VALID), 32'd1);
        chk("add_res", 32'(RES_DATA), 32'd7);
        @(posedge CLK); #1;
        chk("rv_one_cycle", 32'(RES_VALID), 32'd0);

        send_str("9 2-4*=");
        chk("sub_mul_res", 32'(RES_DATA), 32'd28);
        send_str("27-=");
        chk("neg_res", 32'(RES_DATA), 32'h0000FFFB);

        send_str("07-2");
        send("/");
        busy_cycles(n);
        chk("div_busy_cycles", 32'(n), 32'd17);
        send("=");
        chk("div_neg_res", 32'(RES_DATA), 32'h0000FFFD);
        send_str("72/=");
        chk("div_pos_res", 32'(RES_DATA), 32'd3);

        send_str("50/");
        chk("div0_err", 32'(ERR), 32'd1);
        chk("div0_code", 32'(ERR_CODE), 32'd2);
        send("=");
        chk("div0_no_rv", 32'(RES_VALID), 32'd0);
        chk("div0_recover", 32'(ERR), 32'd0);
        send_str("11+=");
        chk("after_div0_res", 32'(RES_DATA), 32'd2);

        send("+");
        chk("under_code", 32'(ERR_CODE), 32'd0);
        chk("under_err", 32'(ERR), 32'd1);
        send("=");
        chk("under_recover", 32'(ERR), 32'd0);

        for (int i = 0; i < DEPTH; i++) send("5");
        chk("full_no_err", 32'(ERR), 32'd0);
        send("5");
        chk("over_err", 32'(ERR), 32'd1);
        chk("over_code", 32'(ERR_CODE), 32'd1);
        send("=");
        chk("over_recover", 32'(ERR), 32'd0);

        send_str("12=");
        chk("bad_eq_code", 32'(ERR_CODE), 32'd3);
        send("=");
        chk("bad_eq_recover", 32'(ERR), 32'd0);
        send("a");
        chk("bad_tok_code", 32'(ERR_CODE), 32'd3);
        send_str("9+=");
        chk("bad_tok_recover", 32'(ERR), 32'd0);

        // 8^5 wraps to -32768; dividing by -1 must wrap back to -32768
        send_str("88*8*8*8*01-/=");
        chk("min_div_neg1", 32'(RES_DATA), 32'h00008000);

        send_str("92/");
        repeat (5) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        check_reset_values("mid_div_reset");
        @(posedge CLK); #1;
        RST = 1'b0;
        model_reset();
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK); #1;
            chk("no_rv_after_reset", 32'(RES_VALID), 32'd0);
        end
        chk("res_after_reset", 32'(RES_DATA), 32'd0);
        send_str("99*=");
        chk("mul_after_reset", 32'(RES_DATA), 32'd81);

        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      tok = 8'(48 + $urandom_range(0, 9));
            else if (r < 57) tok = 8'd43;
            else if (r < 65) tok = 8'd45;
            else if (r < 71) tok = 8'd42;
            else if (r < 77) tok = 8'd47;
            else if (r < 82) tok = 8'd32;
            else if (r < 96) tok = 8'd61;
            else             tok = bad_toks[$urandom_range(0, 3)];
            send(tok);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLK); #1;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
